// File: rtl/uart_tx_arbiter.sv
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter: round-robin, one-byte-per-grant sharing of a UART_TX.   |
// | Optional macro ARB_TIMEOUT_EN adds a START timeout.  Rev 1.0             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module uart_tx_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 1023
`endif
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          ack,
  input  logic                     tx_ready,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic [15:0]              byte_cnt,
  output logic                     err
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   rr, rr_nx;
  logic [NREQ-1:0]    ack_nx;
  logic               tx_start_nx;
  logic [DATA_W-1:0]  tx_data_nx;
  logic [IDX_W-1:0]   owner_nx;
  logic               busy_nx;
  logic [15:0]        byte_cnt_nx;
  logic               err_nx;

  logic               found_hi, found_lo, grant_valid;
  logic [IDX_W-1:0]   win_hi, win_lo, winner;
  logic [DATA_W-1:0]  win_data;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]    to_cnt, to_cnt_nx;
`endif

  // Search above the pointer first, then wrap to the low indices.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_hi && req[i] && (i > int'(rr))) begin
        found_hi = 1'b1;
        win_hi   = IDX_W'(i);
      end
      if (!found_lo && req[i] && (i <= int'(rr))) begin
        found_lo = 1'b1;
        win_lo   = IDX_W'(i);
      end
    end
    grant_valid = found_hi | found_lo;
    winner      = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == winner) begin
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nx    = state;
    rr_nx       = rr;
    ack_nx      = '0;
    tx_start_nx = tx_start;
    tx_data_nx  = tx_data;
    owner_nx    = owner;
    busy_nx     = busy;
    byte_cnt_nx = byte_cnt;
    err_nx      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    to_cnt_nx   = to_cnt;
`endif
    case (state)
      IDLE: begin
        tx_start_nx = 1'b0;
        busy_nx     = 1'b0;
        if (tx_ready && grant_valid) begin
          state_nx    = START;
          tx_data_nx  = win_data;
          owner_nx    = winner;
          ack_nx      = NREQ'(1) << winner;
          tx_start_nx = 1'b1;
          busy_nx     = 1'b1;
`ifdef ARB_TIMEOUT_EN
          to_cnt_nx   = '0;
`endif
        end
      end
      START: begin
        tx_start_nx = 1'b1;
        busy_nx     = 1'b1;
        if (!tx_ready) begin
          tx_start_nx = 1'b0;
          state_nx    = WAIT_DONE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (to_cnt == TO_W'(TIMEOUT)) begin
          // Transmitter never acknowledged: drop the byte but still rotate.
          err_nx      = 1'b1;
          tx_start_nx = 1'b0;
          busy_nx     = 1'b0;
          rr_nx       = owner;
          state_nx    = IDLE;
        end else begin
          to_cnt_nx   = to_cnt + TO_W'(1);
        end
`endif
      end
      WAIT_DONE: begin
        tx_start_nx = 1'b0;
        busy_nx     = 1'b1;
        if (tx_ready) begin
          byte_cnt_nx = byte_cnt + 16'd1;
          rr_nx       = owner;
          busy_nx     = 1'b0;
          state_nx    = IDLE;
        end
      end
      default: begin
        tx_start_nx = 1'b0;
        busy_nx     = 1'b0;
        state_nx    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rr       <= IDX_W'(NREQ - 1);
      ack      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      byte_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      rr       <= rr_nx;
      ack      <= ack_nx;
      tx_start <= tx_start_nx;
      tx_data  <= tx_data_nx;
      owner    <= owner_nx;
      busy     <= busy_nx;
      byte_cnt <= byte_cnt_nx;
      err      <= err_nx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt_nx;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_uart_tx_arbiter: directed bench with a 1-clock-per-bit UART_TX model. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  owner;
  logic        busy;
  logic [15:0] byte_cnt;
  logic        err;

  int errors = 0;
  int checks = 0;
  int multi  = 0;

  logic       model_en  = 1'b1;
  logic       man_ready = 1'b1;
  logic       m_ready   = 1'b1;
  logic       m_busy    = 1'b0;
  logic [9:0] m_sh      = '1;
  int         m_n       = 0;
  logic       txd       = 1'b1;

  logic       rx_busy = 1'b0;
  int         rx_n    = 0;
  logic [7:0] rx_sh   = '0;
  logic [7:0] rx_q[$];
  logic [3:0] got;

  always #5 clk = ~clk;

  assign tx_ready = model_en ? m_ready : man_ready;

  uart_tx_arbiter #(
    .NREQ(4),
    .DATA_W(8)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT(15)
`endif
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_data(req_data), .ack(ack),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
    .owner(owner), .busy(busy), .byte_cnt(byte_cnt), .err(err)
  );

  // Transmitter model: start bit, 8 data bits LSB first, stop bit.
  always @(negedge clk) begin
    if (!rstn) begin
      m_busy  <= 1'b0;
      m_ready <= 1'b1;
      txd     <= 1'b1;
      m_n     <= 0;
    end else if (!m_busy) begin
      if (model_en && tx_start) begin
        m_busy  <= 1'b1;
        m_sh    <= {1'b1, tx_data, 1'b0};
        m_n     <= 0;
        m_ready <= 1'b0;
      end
    end else if (m_n < 10) begin
      txd  <= m_sh[0];
      m_sh <= m_sh >> 1;
      m_n  <= m_n + 1;
    end else begin
      txd     <= 1'b1;
      m_ready <= 1'b1;
      m_busy  <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rstn) begin
      rx_busy <= 1'b0;
    end else if (!rx_busy) begin
      if (txd == 1'b0) begin
        rx_busy <= 1'b1;
        rx_n    <= 0;
      end
    end else if (rx_n < 8) begin
      rx_sh[rx_n] <= txd;
      rx_n        <= rx_n + 1;
    end else begin
      rx_q.push_back(rx_sh);
      rx_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (ack != 4'b0 && !$onehot(ack)) multi <= multi + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag, output logic [3:0] g);
    int n = 0;
    do begin
      tick();
      n++;
    end while (ack == 4'b0 && n < 100);
    g = ack;
    if (ack == 4'b0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=no_ack expected=ack within 100 cycles", tag);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=busy expected=idle within 100 cycles", tag);
    end
  endtask

  initial begin
    rstn     = 1'b0;
    req      = '0;
    req_data = '0;
    repeat (3) tick();
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_start", 32'(tx_start), 32'h0);
    check("rst_data", 32'(tx_data), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cnt", 32'(byte_cnt), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle20", {11'b0, busy, tx_start, ack, byte_cnt}, 32'h0);
    end

    // Single byte from requester 0
    req           = 4'b0001;
    req_data[7:0] = 8'h41;
    tick();
    check("b41_ack", 32'(ack), 32'h1);
    check("b41_data", 32'(tx_data), 32'h41);
    check("b41_start", 32'(tx_start), 32'h1);
    check("b41_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    tick();
    check("b41_ack_pulse", 32'(ack), 32'h0);
    check("b41_start_fall", 32'(tx_start), 32'h0);
    wait_idle("b41_done");
    check("b41_cnt", 32'(byte_cnt), 32'h1);
    check("b41_rxn", 32'(rx_q.size()), 32'h1);
    if (rx_q.size() > 0) check("b41_rx", 32'(rx_q[0]), 32'h41);

    // Fresh pointer, then all four requesting continuously
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    rx_q.delete();
    req_data = 32'h13121110;
    req      = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      wait_ack("rr_wait", got);
      check("rr_ack", 32'(got), 32'(4'b0001 << (g % 4)));
      check("rr_data", 32'(tx_data), 32'h10 + 32'(g % 4));
    end
    req = 4'b0000;
    wait_idle("rr_done");
    check("rr_cnt", 32'(byte_cnt), 32'd8);
    check("rr_rxn", 32'(rx_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      check("rr_rx", 32'(rx_q[i]), 32'h10 + 32'(i % 4));
    end

    // Reset during WAIT_DONE of 0x55 from requester 1
    req_data[15:8] = 8'h55;
    req            = 4'b0010;
    wait_ack("r55_wait", got);
    check("r55_ack", 32'(got), 32'h2);
    check("r55_owner", 32'(owner), 32'h1);
    check("r55_data", 32'(tx_data), 32'h55);
    req = 4'b0000;
    tick();
    check("r55_wait_done", 32'(tx_start), 32'h0);
    repeat (3) tick();
    #2 rstn = 1'b0;
    #1;
    check("async_start", 32'(tx_start), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    check("async_owner", 32'(owner), 32'h0);
    check("async_cnt", 32'(byte_cnt), 32'h0);
    check("async_data", 32'(tx_data), 32'h0);
    tick();
    tick();
    rstn = 1'b1;
    rx_q.delete();
    req_data[7:0]   = 8'h66;
    req_data[31:24] = 8'h99;
    req             = 4'b1001;
    wait_ack("post_rst_wait", got);
    check("post_rst_ack", 32'(got), 32'h1);
    check("post_rst_data", 32'(tx_data), 32'h66);
    req = 4'b0000;
    wait_idle("post_rst_done");
    check("post_rst_cnt", 32'(byte_cnt), 32'h1);
    if (rx_q.size() > 0) check("post_rst_rx", 32'(rx_q[0]), 32'h66);

    // Transmitter not ready: no grant until it is
    model_en  = 1'b0;
    man_ready = 1'b0;
    req       = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("nrdy_ack", 32'(ack), 32'h0);
      check("nrdy_busy", 32'(busy), 32'h0);
    end
    man_ready = 1'b1;
    tick();
    check("rdy_ack", 32'(ack), 32'h2);
    check("rdy_owner", 32'(owner), 32'h1);
    req = 4'b0000;

    // tx_ready stuck high in START
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("stuck_err", 32'(err), 32'h0);
      check("stuck_start", 32'(tx_start), 32'h1);
    end
`ifdef ARB_TIMEOUT_EN
    tick();
    check("to_err", 32'(err), 32'h1);
    check("to_start", 32'(tx_start), 32'h0);
    check("to_busy", 32'(busy), 32'h0);
    tick();
    check("to_err_pulse", 32'(err), 32'h0);
    check("to_cnt", 32'(byte_cnt), 32'h1);
`else
    for (int k = 0; k < 10; k++) begin
      tick();
      check("noto_start", 32'(tx_start), 32'h1);
      check("noto_err", 32'(err), 32'h0);
      check("noto_busy", 32'(busy), 32'h1);
    end
    check("noto_cnt", 32'(byte_cnt), 32'h1);
`endif

    check("ack_onehot", 32'(multi), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
